// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: round-robin grant, broadcast, snoop reply collection,
// writeback and memory sequencing for N_PROC MESI tiles sharing one memory.
module snoop_bus_arbiter #(
  parameter int N_PROC  = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PROC-1:0]        req,
  input  logic [N_PROC-1:0]        req_write,
  input  logic [N_PROC*ADDR_W-1:0] req_addr,
  input  logic [N_PROC*DATA_W-1:0] req_data,
  output logic [N_PROC-1:0]        grant,
  output logic [N_PROC-1:0]        snooping,
  output logic                     bus_valid,
  output logic                     bus_write,
  output logic [ADDR_W-1:0]        bus_addr,
  input  logic [N_PROC-1:0]        snoop_share,
  input  logic [N_PROC-1:0]        snoop_abort,
  input  logic [N_PROC*DATA_W-1:0] snoop_wb_data,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_share,
  output logic                     busy
);

  localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BCAST = 3'd1,
    SNOOP = 3'd2,
    WB    = 3'd3,
    MEM   = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [PW-1:0]       ptr, owner, win, supplier, cand;
  logic                found;
  int                  cand_sum;
  logic [N_PROC-1:0]   own_vec, abort_mask, abort_now;
  logic                op_write, shared_flag;
  logic [ADDR_W-1:0]   op_addr, sel_addr;
  logic [DATA_W-1:0]   op_data, sel_data, sup_data, rd_data, resp_data_hold;
  logic                sel_write, resp_share_hold;
  logic [CW-1:0]       cnt;

  // Round-robin winner search starting one past the last owner, plus winner field muxing.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    cand_sum  = 0;
    for (int i = 1; i <= N_PROC; i++) begin
      cand_sum = int'(ptr) + i;
      cand     = (cand_sum >= N_PROC) ? PW'(cand_sum - N_PROC) : PW'(cand_sum);
      win      = (!found && req[cand]) ? cand : win;
      found    = found | req[cand];
    end
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < N_PROC; i++) begin
      sel_write = (win == PW'(i)) ? req_write[i] : sel_write;
      sel_addr  = (win == PW'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr;
      sel_data  = (win == PW'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data;
    end
  end

  // Owner one-hot, masked abort view and lowest-index writeback supplier.
  always_comb begin
    own_vec   = '0;
    for (int i = 0; i < N_PROC; i++) begin
      own_vec[i] = (owner == PW'(i));
    end
    abort_now = snoop_abort & ~own_vec;
    supplier  = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      supplier = abort_mask[i] ? PW'(i) : supplier;
    end
    sup_data  = '0;
    for (int i = 0; i < N_PROC; i++) begin
      sup_data = (supplier == PW'(i)) ? snoop_wb_data[i*DATA_W +: DATA_W] : sup_data;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = found ? BCAST : IDLE;
      BCAST:   state_next = SNOOP;
      SNOOP:   state_next = (|abort_now) ? WB : MEM;
      WB:      state_next = MEM;
      MEM:     state_next = (cnt == CW'(1)) ? RESP : MEM;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: latched request, snoop results, latency counter, read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr             <= PW'(N_PROC - 1);
      owner           <= '0;
      op_write        <= 1'b0;
      op_addr         <= '0;
      op_data         <= '0;
      abort_mask      <= '0;
      shared_flag     <= 1'b0;
      cnt             <= '0;
      rd_data         <= '0;
      resp_data_hold  <= '0;
      resp_share_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner    <= win;
            op_write <= sel_write;
            op_addr  <= sel_addr;
            op_data  <= sel_data;
          end else begin
            owner    <= owner;
          end
        end
        SNOOP: begin
          abort_mask  <= abort_now;
          shared_flag <= |((snoop_share | snoop_abort) & ~own_vec);
          cnt         <= CW'(MEM_LAT);
        end
        WB: begin
          rd_data <= sup_data;
          cnt     <= CW'(MEM_LAT);
        end
        MEM: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1) && !op_write) begin
            rd_data <= mem_rdata;
          end else begin
            rd_data <= rd_data;
          end
        end
        RESP: begin
          ptr             <= owner;
          resp_data_hold  <= rd_data;
          resp_share_hold <= shared_flag;
        end
        default: begin
          ptr <= ptr;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state; response fields persist between completions.
  always_comb begin
    grant      = (state == IDLE) ? '0 : own_vec;
    snooping   = '0;
    bus_valid  = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_data  = resp_data_hold;
    resp_share = resp_share_hold;
    busy       = (state != IDLE);
    case (state)
      BCAST: begin
        snooping  = ~own_vec;
        bus_valid = 1'b1;
        bus_write = op_write;
        bus_addr  = op_addr;
      end
      SNOOP: snooping = ~own_vec;
      WB: begin
        mem_we    = 1'b1;
        mem_addr  = op_addr;
        mem_wdata = sup_data;
      end
      MEM: begin
        mem_we    = op_write && (cnt == CW'(MEM_LAT));
        mem_addr  = op_addr;
        mem_wdata = op_write ? op_data : '0;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = rd_data;
        resp_share = shared_flag;
      end
      default: busy = (state != IDLE);
    endcase
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: directed transactions push expected
// responses and memory writes; negedge monitors pop and compare.
module tb_snoop_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, req_write;
  logic [14:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  grant, snooping;
  logic        bus_valid, bus_write;
  logic [4:0]  bus_addr;
  logic [2:0]  snoop_share, snoop_abort;
  logic [23:0] snoop_wb_data;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_share;
  logic        busy;

  typedef struct {
    logic [7:0] data;
    logic       share;
    logic [2:0] grant;
    int         at;
    bit         chk_data;
  } resp_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         at;
  } mw_t;

  resp_t exp_q[$];
  mw_t   mw_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic [7:0] mem [32];

  snoop_bus_arbiter #(.N_PROC(3), .ADDR_W(5), .DATA_W(8), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .grant(grant), .snooping(snooping),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .snoop_share(snoop_share), .snoop_abort(snoop_abort), .snoop_wb_data(snoop_wb_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_share(resp_share), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int k);
    case (k)
      0:       return 8'h10;
      1:       return 8'h21;
      2:       return 8'h32;
      5:       return 8'hA5;
      12:      return 8'hC3;
      default: return 8'h00;
    endcase
  endfunction

  // Memory model: combinational read, write on posedge, contents restored on reset.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) mem[k] <= init_val(k);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected responses and memory writes as the DUT presents them.
  always @(negedge clock) begin
    resp_t e;
    mw_t   m;
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {29'd0, grant}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_grant", {29'd0, grant}, {29'd0, e.grant});
        check("resp_share", {31'd0, resp_share}, {31'd0, e.share});
        check("resp_cycle", cyc, e.at);
        if (e.chk_data) check("resp_data", {24'd0, resp_data}, {24'd0, e.data});
      end
    end
    if (mem_we) begin
      if (mw_q.size() == 0) begin
        check("mem_we_unexpected", {31'd0, mem_we}, 32'd0);
      end else begin
        m = mw_q.pop_front();
        check("mem_waddr", {27'd0, mem_addr}, {27'd0, m.addr});
        check("mem_wdata", {24'd0, mem_wdata}, {24'd0, m.data});
        check("mem_wcycle", cyc, m.at);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_tile(input int i, input logic w, input logic [4:0] a, input logic [7:0] d);
    req_write[i]        = w;
    req_addr[i*5 +: 5]  = a;
    req_data[i*8 +: 8]  = d;
  endtask

  task automatic push_resp(input logic [7:0] d, input logic sh, input logic [2:0] g,
                           input int lat, input bit chk);
    exp_q.push_back('{data: d, share: sh, grant: g, at: cyc + lat, chk_data: chk});
  endtask

  task automatic push_mw(input logic [4:0] a, input logic [7:0] d, input int lat);
    mw_q.push_back('{addr: a, data: d, at: cyc + lat});
  endtask

  task automatic wait_resp(input bit drop);
    int n;
    n = 0;
    @(negedge clock);
    while (!resp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("resp_timeout", {31'd0, resp_valid}, 32'd1);
    if (drop) begin
      tick();
      req           = 3'b000;
      snoop_share   = 3'b000;
      snoop_abort   = 3'b000;
      snoop_wb_data = 24'h0;
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 3'b000; req_write = 3'b000; req_addr = '0; req_data = '0;
    snoop_share = 3'b000; snoop_abort = 3'b000; snoop_wb_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_grant", {29'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_resp", {23'd0, resp_valid, resp_data}, 32'd0);

    // All three tiles request permanently: 001, 010, 100, 001.
    tick();
    set_tile(0, 1'b0, 5'd0, 8'h00);
    set_tile(1, 1'b0, 5'd1, 8'h00);
    set_tile(2, 1'b0, 5'd2, 8'h00);
    req = 3'b111;
    push_resp(8'h10, 1'b0, 3'b001, 4, 1'b1);
    push_resp(8'h21, 1'b0, 3'b010, 9, 1'b1);
    push_resp(8'h32, 1'b0, 3'b100, 14, 1'b1);
    push_resp(8'h10, 1'b0, 3'b001, 19, 1'b1);
    repeat (3) wait_resp(1'b0);
    wait_resp(1'b1);

    // Tile1 read addr5, no snoop replies.
    tick();
    set_tile(1, 1'b0, 5'd5, 8'h00);
    req = 3'b010;
    push_resp(8'hA5, 1'b0, 3'b010, 4, 1'b1);
    @(negedge clock);
    check("t1_idle_grant", {29'd0, grant}, 32'd0);
    @(negedge clock);
    check("t1_bcast_grant", {29'd0, grant}, 32'd2);
    check("t1_bcast_bus", {25'd0, bus_valid, bus_write, bus_addr}, {25'd0, 1'b1, 1'b0, 5'd5});
    check("t1_snooping", {29'd0, snooping}, 32'd5);
    wait_resp(1'b1);

    // Tile0 read addr3; tile2 aborts with 3C, owner's own abort bit is ignored.
    tick();
    set_tile(0, 1'b0, 5'd3, 8'h00);
    snoop_abort   = 3'b101;
    snoop_wb_data = {8'h3C, 8'h00, 8'hFF};
    req = 3'b001;
    push_mw(5'd3, 8'h3C, 3);
    push_resp(8'h3C, 1'b1, 3'b001, 5, 1'b1);
    wait_resp(1'b1);

    // Tile1 read addr9 with aborts from tiles 0 and 2: lowest index supplies.
    tick();
    set_tile(1, 1'b0, 5'd9, 8'h00);
    snoop_abort   = 3'b101;
    snoop_wb_data = {8'h77, 8'h00, 8'h5A};
    req = 3'b010;
    push_mw(5'd9, 8'h5A, 3);
    push_resp(8'h5A, 1'b1, 3'b010, 5, 1'b1);
    wait_resp(1'b1);

    // Tile2 write addr7 data 11; tile0 shares.
    tick();
    set_tile(2, 1'b1, 5'd7, 8'h11);
    snoop_share = 3'b001;
    req = 3'b100;
    push_mw(5'd7, 8'h11, 3);
    push_resp(8'h00, 1'b1, 3'b100, 4, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("t4_bcast_snooping", {29'd0, snooping}, 32'd3);
    check("t4_bcast_bus", {25'd0, bus_valid, bus_write, bus_addr}, {25'd0, 1'b1, 1'b1, 5'd7});
    @(negedge clock);
    check("t4_snoop_snooping", {29'd0, snooping}, 32'd3);
    wait_resp(1'b1);
    check("t4_mem7", {24'd0, mem[7]}, 32'h11);
    set_tile(2, 1'b0, 5'd0, 8'h00);

    // Tile1 drops req during SNOOP; transaction still completes.
    tick();
    set_tile(1, 1'b0, 5'd12, 8'h00);
    req = 3'b010;
    push_resp(8'hC3, 1'b0, 3'b010, 4, 1'b1);
    tick();
    tick();
    req = 3'b000;
    wait_resp(1'b1);
    @(negedge clock);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    @(negedge clock);
    check("t6_stay_idle", {28'd0, busy, grant}, 32'd0);

    // Reset in MEM aborts the read; then req=101 goes to tile0 first.
    tick();
    set_tile(1, 1'b0, 5'd5, 8'h00);
    req = 3'b010;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 3'b000;
    @(negedge clock);
    check("t5_grant", {29'd0, grant}, 32'd0);
    check("t5_mem_we", {31'd0, mem_we}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    tick();
    set_tile(0, 1'b0, 5'd0, 8'h00);
    set_tile(2, 1'b0, 5'd2, 8'h00);
    req = 3'b101;
    push_resp(8'h10, 1'b0, 3'b001, 4, 1'b1);
    wait_resp(1'b1);
    repeat (3) tick();

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("mw_q_empty", mw_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
